tdm_demux: RTL and testbench

- Time-division demultiplexer: the receive end of a TDM serializer that muxes N channel samples onto one shared data bus.
- Accepts one sample per valid beat, starting at a frame-start marker, and steers each sample to its channel slot.
- Publishes all N channels atomically once a full frame has arrived.
- Detects and recovers from framing errors by hunting for the next frame-start.

---
 rtl/tdm_demux_if.sv | 30 +++
 rtl/tdm_demux.sv | 85 ++++++++
 tb/tb_tdm_demux.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: bus bundle between a TDM sample source and tdm_demux.
//   din/din_valid/frame_start : multiplexed sample stream (source -> demux)
//   ch_data                   : published frame, channel k at [k*W +: W]
//   frame_valid / sync_err    : one-cycle completion / framing-error pulses
//   locked                    : demux is receiving (not hunting)
//   frame_count               : completed frames, wrapping counter
interface tdm_demux_if #(
  parameter int unsigned W    = 8,
  parameter int unsigned N    = 4,
  parameter int unsigned FC_W = 8
);
  logic [W-1:0]    din;
  logic            din_valid;
  logic            frame_start;
  logic [N*W-1:0]  ch_data;
  logic            frame_valid;
  logic            sync_err;
  logic            locked;
  logic [FC_W-1:0] frame_count;

  modport master (
    output din, din_valid, frame_start,
    input  ch_data, frame_valid, sync_err, locked, frame_count
  );

  modport slave (
    input  din, din_valid, frame_start,
    output ch_data, frame_valid, sync_err, locked, frame_count
  );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: receive side of a TDM serializer. Collects N samples per frame
// (first one marked by frame_start) into shadow registers and publishes the
// whole frame atomically on ch_data. Framing errors pulse sync_err; a missing
// start drops back to hunting for the next frame_start.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : tdm_demux_if.slave (din, din_valid, frame_start in;
//           ch_data, frame_valid, sync_err, locked, frame_count out)
module tdm_demux #(
  parameter int unsigned W    = 8,
  parameter int unsigned N    = 4,
  parameter int unsigned FC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  tdm_demux_if.slave  bus
);
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] IDX_ONE  = CW'(1);
  localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                  state;
  logic [CW-1:0]           idx;
  // Only channels 0..N-2 need holding; the last sample goes straight to ch_data.
  logic [N-2:0][W-1:0]     shadow;
  logic [N*W-1:0]          ch_q;
  logic                    frame_valid_q;
  logic                    sync_err_q;
  logic [FC_W-1:0]         count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      shadow        <= '0;
      ch_q          <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      count_q       <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (bus.din_valid) begin
        unique case (state)
          IDLE: begin
            if (bus.frame_start) begin
              shadow[0] <= bus.din;
              idx       <= IDX_ONE;
              state     <= RECV;
            end
          end
          RECV: begin
            if (bus.frame_start) begin
              // Early start discards the partial frame and restarts from here.
              if (idx != '0) sync_err_q <= 1'b1;
              shadow[0] <= bus.din;
              idx       <= IDX_ONE;
            end else if (idx == '0) begin
              sync_err_q <= 1'b1;
              state      <= IDLE;
            end else if (idx == IDX_LAST) begin
              ch_q          <= {bus.din, shadow};
              frame_valid_q <= 1'b1;
              count_q       <= count_q + FC_W'(1);
              idx           <= '0;
            end else begin
              shadow[idx] <= bus.din;
              idx         <= idx + IDX_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ch_data     = ch_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = (state == RECV);
  assign bus.frame_count = count_q;
endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;
  localparam int unsigned W    = 8;
  localparam int unsigned N    = 4;
  localparam int unsigned FC_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tdm_demux_if #(.W(W), .N(N), .FC_W(FC_W)) bus ();

  tdm_demux #(.W(W), .N(N), .FC_W(FC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of the samples of the frame in progress,
  // plus a hunting flag. Expected outputs describe the state after the edge.
  logic [W-1:0]    q[$];
  bit              hunting;
  logic [N*W-1:0]  exp_ch;
  bit              exp_fv, exp_se;
  logic [FC_W-1:0] exp_cnt;
  int unsigned     fv_seen;

  task automatic model_reset();
    q.delete();
    hunting = 1;
    exp_ch  = '0;
    exp_fv  = 0;
    exp_se  = 0;
    exp_cnt = '0;
  endtask

  task automatic model_step(input bit v, input bit fs, input logic [W-1:0] d);
    exp_fv = 0;
    exp_se = 0;
    if (!v) return;
    if (hunting) begin
      if (fs) begin
        q.delete();
        q.push_back(d);
        hunting = 0;
      end
    end else if (fs) begin
      if (q.size() != 0) exp_se = 1;
      q.delete();
      q.push_back(d);
    end else if (q.size() == 0) begin
      exp_se  = 1;
      hunting = 1;
    end else begin
      q.push_back(d);
      if (q.size() == N) begin
        for (int k = 0; k < N; k++) exp_ch[k*W +: W] = q[k];
        exp_fv  = 1;
        exp_cnt = exp_cnt + 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".fv"},   64'(bus.frame_valid), 64'(exp_fv));
    chk({tag, ".se"},   64'(bus.sync_err),    64'(exp_se));
    chk({tag, ".lock"}, 64'(bus.locked),      64'(!hunting));
    chk({tag, ".ch"},   64'(bus.ch_data),     64'(exp_ch));
    chk({tag, ".cnt"},  64'(bus.frame_count), 64'(exp_cnt));
    chk({tag, ".excl"}, 64'(bus.frame_valid & bus.sync_err), 64'(0));
    if (bus.frame_valid) fv_seen++;
  endtask

  // One clock: drive inputs, take the edge, update model, check #1 later.
  task automatic cyc(input bit v, input bit fs, input logic [W-1:0] d, input string tag);
    bus.din_valid   = v;
    bus.frame_start = fs;
    bus.din         = d;
    @(posedge clk);
    model_step(v, fs, d);
    #1;
    check_all(tag);
  endtask

  task automatic idle_cycles(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++)
      cyc(1'b0, 1'($urandom_range(0, 1)), W'($urandom), tag);
  endtask

  task automatic do_reset();
    bus.din_valid = 1'b0;
    bus.frame_start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_all("rst");
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [N*W-1:0] f, input string tag);
    for (int k = 0; k < N; k++) cyc(1'b1, k == 0, f[k*W +: W], tag);
  endtask

  initial begin
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.frame_start = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Basic frame
    send_frame(32'h44332211, "t1");
    chk("t1_ch", 64'(bus.ch_data), 64'h44332211);
    chk("t1_fv", 64'(bus.frame_valid), 64'd1);
    chk("t1_cnt", 64'(bus.frame_count), 64'd1);
    chk("t1_lock", 64'(bus.locked), 64'd1);
    idle_cycles(1, "t1i");
    chk("t1_fv_off", 64'(bus.frame_valid), 64'd0);

    // Beats in IDLE without start are dropped silently
    do_reset();
    cyc(1'b1, 1'b0, 8'hAA, "t2a");
    chk("t2_se_a", 64'(bus.sync_err), 64'd0);
    cyc(1'b1, 1'b0, 8'hBB, "t2b");
    chk("t2_se_b", 64'(bus.sync_err), 64'd0);
    send_frame(32'h04030201, "t2");
    chk("t2_ch", 64'(bus.ch_data), 64'h04030201);

    // Early frame_start
    do_reset();
    fv_seen = 0;
    cyc(1'b1, 1'b1, 8'h01, "t3");
    cyc(1'b1, 1'b0, 8'h02, "t3");
    cyc(1'b1, 1'b1, 8'h55, "t3s");
    chk("t3_se", 64'(bus.sync_err), 64'd1);
    cyc(1'b1, 1'b0, 8'h66, "t3");
    chk("t3_se_off", 64'(bus.sync_err), 64'd0);
    cyc(1'b1, 1'b0, 8'h77, "t3");
    cyc(1'b1, 1'b0, 8'h88, "t3");
    chk("t3_ch", 64'(bus.ch_data), 64'h88776655);
    idle_cycles(2, "t3i");
    chk("t3_nfv", 64'(fv_seen), 64'd1);

    // Missing start after a complete frame
    send_frame(32'hD4C3B2A1, "t4");
    cyc(1'b1, 1'b0, 8'h99, "t4m");
    chk("t4_se", 64'(bus.sync_err), 64'd1);
    chk("t4_lock", 64'(bus.locked), 64'd0);
    chk("t4_ch", 64'(bus.ch_data), 64'hD4C3B2A1);
    cyc(1'b1, 1'b1, 8'h10, "t4r");
    chk("t4_relock", 64'(bus.locked), 64'd1);
    cyc(1'b1, 1'b0, 8'h20, "t4r");
    cyc(1'b1, 1'b0, 8'h30, "t4r");
    cyc(1'b1, 1'b0, 8'h40, "t4r");
    chk("t4_ch2", 64'(bus.ch_data), 64'h40302010);

    // Gaps of 0, 3 and 7 idle cycles mid-frame
    do_reset();
    cyc(1'b1, 1'b1, 8'h11, "t5");
    cyc(1'b1, 1'b0, 8'h22, "t5");
    idle_cycles(3, "t5g");
    cyc(1'b1, 1'b0, 8'h33, "t5");
    idle_cycles(7, "t5g");
    cyc(1'b1, 1'b0, 8'h44, "t5");
    chk("t5_ch", 64'(bus.ch_data), 64'h44332211);

    // 256 back-to-back frames: counter wraps
    do_reset();
    fv_seen = 0;
    for (int f = 0; f < 256; f++) send_frame(32'($urandom), "t6");
    chk("t6_wrap", 64'(bus.frame_count), 64'd0);
    chk("t6_nfv", 64'(fv_seen), 64'd256);

    // Asynchronous reset mid-cycle after two samples
    send_frame(32'hCAFEF00D, "t7p");
    cyc(1'b1, 1'b1, 8'h01, "t7");
    cyc(1'b1, 1'b0, 8'h02, "t7");
    bus.din_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t7_ch0",  64'(bus.ch_data), 64'd0);
    chk("t7_cnt0", 64'(bus.frame_count), 64'd0);
    chk("t7_lock0", 64'(bus.locked), 64'd0);
    chk("t7_fv0",  64'(bus.frame_valid), 64'd0);
    chk("t7_se0",  64'(bus.sync_err), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_frame(32'h5A6B7C8D, "t7");
    chk("t7_ch", 64'(bus.ch_data), 64'h5A6B7C8D);
    chk("t7_cnt", 64'(bus.frame_count), 64'd1);

    // Random traffic with occasional framing errors
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit v, fs;
      v  = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 5) == 0);
      cyc(v, fs, W'($urandom), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
